// File: rtl/cordic_vectoring.sv
// Vectoring-mode CORDIC. It takes a Cartesian vector (x_in, y_in) in Q1.14 and
// returns atan2(y, x) and the gain-compensated magnitude, both in Q2.14.
// It uses a start/done single-shot handshake, and each operation takes
// N_ITER+1 edges after the start edge.
module cordic_vectoring #(
    parameter int WL     = 16,
    parameter int FL     = 14,
    parameter int N_ITER = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [WL-1:0] x_in,
    input  logic signed [WL-1:0] y_in,
    output logic signed [WL:0]   angle_out,
    output logic signed [WL:0]   mag_out,
    output logic                 done
);

    localparam int DW = WL + 2;          // Q3.14 internal datapath
    localparam int IW = 5;               // holds 0..16
    localparam int PW = 2 * DW;          // scale product width
    localparam logic signed [DW-1:0] Z90    = DW'(25736);
    localparam logic signed [PW-1:0] K_GAIN = PW'(9949);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE} state_t;

    state_t               r_state, w_next;
    logic signed [DW-1:0] r_x, r_y, r_z;
    logic [IW-1:0]        r_i;
    logic                 r_zero;
    logic signed [WL:0]   r_angle, r_mag;
    logic                 r_done;

    logic signed [DW-1:0] w_xe, w_ye, w_fx, w_fy, w_fz;
    logic signed [DW-1:0] w_xs, w_ys, w_nx, w_ny, w_nz, w_atan;
    logic signed [PW-1:0] w_xw, w_prod;
    logic                 w_zin, w_last;
    logic                 w_unused_bits;

    // Arctangent table in Q2.14. Entries past index 14 round to zero.
    function automatic logic signed [DW-1:0] atan_lut(input logic [IW-1:0] idx);
        case (idx)
            5'd0:    atan_lut = DW'(12868);
            5'd1:    atan_lut = DW'(7596);
            5'd2:    atan_lut = DW'(4014);
            5'd3:    atan_lut = DW'(2037);
            5'd4:    atan_lut = DW'(1023);
            5'd5:    atan_lut = DW'(512);
            5'd6:    atan_lut = DW'(256);
            5'd7:    atan_lut = DW'(128);
            5'd8:    atan_lut = DW'(64);
            5'd9:    atan_lut = DW'(32);
            5'd10:   atan_lut = DW'(16);
            5'd11:   atan_lut = DW'(8);
            5'd12:   atan_lut = DW'(4);
            5'd13:   atan_lut = DW'(2);
            5'd14:   atan_lut = DW'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    assign w_xe   = {{2{x_in[WL-1]}}, x_in};
    assign w_ye   = {{2{y_in[WL-1]}}, y_in};
    assign w_zin  = (x_in == '0) && (y_in == '0);
    assign w_last = (r_i == IW'(N_ITER - 1));

    // Quadrant fold: rotate left-half-plane vectors by +/-90 degrees into
    // the right half, where CORDIC converges. y=0, x<0 folds to +90, so the
    // result lands at +pi and never at -pi.
    always_comb begin
        w_fx = w_xe;
        w_fy = w_ye;
        w_fz = '0;
        if (w_xe[DW-1]) begin
            if (!w_ye[DW-1]) begin
                w_fx = w_ye;
                w_fy = -w_xe;
                w_fz = Z90;
            end else begin
                w_fx = -w_ye;
                w_fy = w_xe;
                w_fz = -Z90;
            end
        end
    end

    // One micro-rotation that drives y toward zero while z accumulates the angle.
    always_comb begin
        w_xs   = r_x >>> r_i;
        w_ys   = r_y >>> r_i;
        w_atan = atan_lut(r_i);
        if (!r_y[DW-1]) begin
            w_nx = r_x + w_ys;
            w_ny = r_y - w_xs;
            w_nz = r_z + w_atan;
        end else begin
            w_nx = r_x - w_ys;
            w_ny = r_y + w_xs;
            w_nz = r_z - w_atan;
        end
    end

    // Gain compensation. x stays well below 2^17, so the product fits easily.
    assign w_xw   = {{DW{r_x[DW-1]}}, r_x};
    assign w_prod = w_xw * K_GAIN;
    assign w_unused_bits = &{1'b0, w_prod[PW-1:FL+WL+1], w_prod[FL-1:0], r_z[DW-1]};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ITER;
            S_ITER:  if (w_last) w_next = S_SCALE;
            S_SCALE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: fold on accept, rotate in ITER, scale and publish in SCALE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_i     <= '0;
            r_zero  <= 1'b0;
            r_angle <= '0;
            r_mag   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= w_fx;
                        r_y    <= w_fy;
                        r_z    <= w_fz;
                        r_i    <= '0;
                        r_zero <= w_zin;
                    end
                end
                S_ITER: begin
                    r_x <= w_nx;
                    r_y <= w_ny;
                    r_z <= w_nz;
                    r_i <= r_i + 1'b1;
                end
                S_SCALE: begin
                    r_angle <= r_zero ? '0 : r_z[WL:0];
                    r_mag   <= r_zero ? '0 : w_prod[FL +: WL+1];
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign angle_out = r_angle;
    assign mag_out   = r_mag;
    assign done      = r_done;

endmodule
